// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner: column strobing, row sync, sweep-level debounce,
// and a 4-digit shift register of accepted keys for the 7-segment driver.
module keypad_entry #(
    parameter int unsigned SCAN_DIV = 65536,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        ent_clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] x
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_t;

    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [3:0]       row_s1, row_s2;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;

    logic       sample_c, sweep_end_c, accept_c;
    logic [1:0] col_hits_c, sweep_hits_c;
    logic [3:0] col_code_c, sweep_code_c;
    logic [2:0] hit_sum_c;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Fold this column's sample into the running sweep result (hit count saturates at 2)
    always_comb begin
        col_hits_c = 2'd0;
        col_code_c = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2[r]) begin
                if (col_hits_c != 2'd2) col_hits_c = col_hits_c + 2'd1;
                col_code_c = key_map(2'(r), col_idx);
            end
        end
        hit_sum_c    = {1'b0, acc_hits} + {1'b0, col_hits_c};
        sweep_hits_c = (hit_sum_c >= 3'd2) ? 2'd2 : hit_sum_c[1:0];
        sweep_code_c = (acc_hits != 2'd0) ? acc_code : col_code_c;
        sample_c     = (div == DIV_LAST);
        sweep_end_c  = sample_c && (col_idx == 2'd3);
        accept_c     = 1'b0;
        if (sweep_end_c && sweep_hits_c == 2'd1) begin
            if (state == IDLE && DEBOUNCE == 1)
                accept_c = 1'b1;
            else if (state == CAND && sweep_code_c == cand && (cnt + CNT_ONE) == CNT_MAX)
                accept_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div       <= '0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            acc_hits  <= 2'd0;
            acc_code  <= 4'd0;
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            x         <= 16'h0000;
        end else begin
            row_s1    <= row;
            row_s2    <= row_s1;
            key_valid <= accept_c;

            if (sample_c) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= {col[2:0], col[3]};
            end else begin
                div <= div + DIV_W'(1);
            end

            if (sample_c) begin
                if (sweep_end_c) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'd0;
                end else begin
                    acc_hits <= sweep_hits_c;
                    acc_code <= sweep_code_c;
                end
            end

            if (accept_c) begin
                key_code <= sweep_code_c;
                x        <= ent_clr ? {12'h000, sweep_code_c} : {x[11:0], sweep_code_c};
            end else if (ent_clr) begin
                x <= 16'h0000;
            end

            // Debounce FSM advances once per sweep
            if (sweep_end_c) begin
                case (state)
                    IDLE: begin
                        if (sweep_hits_c == 2'd1) begin
                            cand  <= sweep_code_c;
                            cnt   <= CNT_ONE;
                            state <= (DEBOUNCE == 1) ? PRESSED : CAND;
                        end
                    end
                    CAND: begin
                        if (sweep_hits_c == 2'd1 && sweep_code_c == cand) begin
                            if ((cnt + CNT_ONE) == CNT_MAX) state <= PRESSED;
                            else cnt <= cnt + CNT_ONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (sweep_hits_c == 2'd0) begin
                            cnt   <= CNT_ONE;
                            state <= (DEBOUNCE == 1) ? IDLE : RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (sweep_hits_c == 2'd0) begin
                            if ((cnt + CNT_ONE) == CNT_MAX) state <= IDLE;
                            else cnt <= cnt + CNT_ONE;
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized and directed bench for keypad_entry with a matrix-keypad emulator
// and a sweep-level press/release reference model.
module tb_keypad_entry;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        ent_clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] x;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .clr(clr), .row(row), .col(col), .ent_clr(ent_clr),
        .key_valid(key_valid), .key_code(key_code), .x(x)
    );

    always #5 clk = ~clk;

    // Held keys, bit index r*4+c; rows pulled low through the active column
    logic [15:0] held;
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    logic [3:0] kmap [16];

    // Reference: armed means the keypad has been idle long enough to take a new press
    bit         armed;
    int         run_len, rel_len;
    logic [3:0] run_key;
    logic [15:0] mx;
    logic [3:0]  mcode;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        armed = 1'b1; run_len = 0; rel_len = 0; run_key = 4'd0;
        mx = 16'h0000; mcode = 4'd0;
    endtask

    task automatic model_sweep(input logic [15:0] keys, output bit acc);
        int         nk;
        logic [3:0] k;
        nk = $countones(keys);
        k  = 4'd0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = kmap[i];
        acc = 1'b0;
        if (armed) begin
            if (nk == 1 && (run_len == 0 || run_key == k)) begin
                run_key = k;
                run_len++;
            end else begin
                run_len = 0;
            end
            if (run_len == DB) begin
                acc = 1'b1; armed = 1'b0; rel_len = 0; run_len = 0;
                mcode = k;
                mx = {mx[11:0], k};
            end
        end else begin
            if (nk == 0) begin
                rel_len++;
                if (rel_len == DB) begin armed = 1'b1; run_len = 0; end
            end else begin
                rel_len = 0;
            end
        end
    endtask

    // Runs len cycles of a sweep with keys held; ent_clr pulses on cycle clr_at
    task automatic run_sweep(input logic [15:0] keys, input int clr_at, input int len);
        bit         acc;
        logic [3:0] ecol;
        held = keys;
        for (int i = 0; i < len; i++) begin
            ent_clr = (i == clr_at);
            @(posedge clk); #1;
            ncyc++;
            acc = 1'b0;
            if (ent_clr) mx = 16'h0000;
            if (i == 15) model_sweep(keys, acc);
            ent_clr = 1'b0;
            ecol = ~(4'b0001 << ((ncyc / SD) % 4));
            chk("col", 16'(col), 16'(ecol));
            chk("key_valid", 16'(key_valid), 16'(acc));
        end
        if (len == 16) begin
            chk("x", x, mx);
            chk("key_code", 16'(key_code), 16'(mcode));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clr = 1'b0;
        #1;
        chk("rst_col", 16'(col), 16'h000E);
        chk("rst_valid", 16'(key_valid), 16'h0);
        chk("rst_code", 16'(key_code), 16'h0);
        chk("rst_x", x, 16'h0000);
        model_reset();
        @(negedge clk);
        clr  = 1'b1;
        ncyc = 0;
    endtask

    task automatic press(input logic [15:0] keys, input int on, input int off);
        for (int i = 0; i < on; i++)  run_sweep(keys, -1, 16);
        for (int i = 0; i < off; i++) run_sweep(16'h0, -1, 16);
    endtask

    initial begin
        logic [15:0] m;
        int kind, dur, ca;
        kmap[0]  = 4'h1; kmap[1]  = 4'h2; kmap[2]  = 4'h3; kmap[3]  = 4'hA;
        kmap[4]  = 4'h4; kmap[5]  = 4'h5; kmap[6]  = 4'h6; kmap[7]  = 4'hB;
        kmap[8]  = 4'h7; kmap[9]  = 4'h8; kmap[10] = 4'h9; kmap[11] = 4'hC;
        kmap[12] = 4'h0; kmap[13] = 4'hF; kmap[14] = 4'hE; kmap[15] = 4'hD;
        clr = 1'b0; ent_clr = 1'b0; held = 16'h0;
        model_reset();
        #12;
        do_reset();

        // Idle scanning
        press(16'h0, 0, 2);
        // '5' held 4 sweeps
        press(16'h0020, 4, 3);
        chk("x_0005", x, 16'h0005);
        // '1','2','A','0' then 'F'
        press(16'h0001, 3, 3);
        press(16'h0002, 3, 3);
        press(16'h0008, 3, 3);
        press(16'h1000, 3, 3);
        chk("x_12A0", x, 16'h12A0);
        press(16'h2000, 3, 3);
        chk("x_2A0F", x, 16'h2A0F);
        // Bounce on '7', then clean press
        press(16'h0100, 1, 1);
        press(16'h0100, 1, 2);
        chk("x_bounce", x, 16'h2A0F);
        press(16'h0100, 2, 2);
        chk("code_7", 16'(key_code), 16'h0007);
        // '3' then '3'+'9' while held
        press(16'h0004, 2, 0);
        press(16'h0404, 2, 2);
        chk("x_multi", x, 16'h0F73);
        // Reset during a '6' hold, key kept down across reset
        run_sweep(16'h0040, -1, 16);
        run_sweep(16'h0040, -1, 7);
        do_reset();
        press(16'h0040, 2, 2);
        chk("x_after_rst", x, 16'h0006);
        // ent_clr coincident with accept
        press(16'h0080, 2, 2);
        run_sweep(16'h0800, -1, 16);
        run_sweep(16'h0800, 15, 16);
        chk("x_entclr_acc", x, 16'h000C);
        press(16'h0, 0, 2);
        run_sweep(16'h0, 5, 16);
        chk("x_entclr", x, 16'h0000);

        // Randomized key activity
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            m = 16'h0;
            if (kind >= 4) m[$urandom_range(0, 15)] = 1'b1;
            if (kind == 9) m[$urandom_range(0, 15)] = 1'b1;
            dur = $urandom_range(1, 4);
            for (int d = 0; d < dur; d++) begin
                ca = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
                run_sweep(m, ca, 16);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Scans a 4x4 matrix hex keypad, debounces it, and assembles the keys pressed into a 16-bit, 4-digit hex value.
- This is the input-side counterpart of the multiplexed 7-segment display driver.
- Output x feeds the display driver's 16-bit x input directly.
- Per-key strobe and code outputs are also provided for other consumers.

Parameters:
- SCAN_DIV, 65536: clock cycles each column is held active. Minimum 4.
- DEBOUNCE, 3: number of consecutive identical full sweeps needed to accept a press or a release. Minimum 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous active-low reset; takes effect immediately on assertion.
- row  input  4  keypad row returns, active-low (pulled up externally), asynchronous to clk.
- col  output  4  keypad column strobes, active-low, exactly one bit low at any time.
- ent_clr  input  1  synchronous clear of x, active-high.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_code  output  4  hex value of the last accepted key; held between pulses.
- x  output  16  entered value; new digit shifts in at bits [3:0].

Behaviour:
- Reset (clr=0): col=4'b1110, key_valid=0, key_code=0, x=0, all counters and sync flops cleared, FSM=IDLE.
- Column scan:
  - Divider counts 0..SCAN_DIV-1, then wraps.
  - On wrap, the column index advances 0→1→2→3→0; col = ~(1<<index).
  - Four slots make one sweep of 4*SCAN_DIV cycles.
- Row input:
  - row passes through a 2-flop synchronizer.
  - It is sampled on the last cycle of each slot (divider = SCAN_DIV-1).
  - Key (r,c) is pressed when synced row[r]=0 during column c's sample.
- Sweep result, evaluated at the end of column 3's slot: NONE (no key), ONE(code) (exactly one key), MULTI (two or more keys).
- Key map, row 0..3, columns 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- FSM transitions, evaluated once per sweep end:
  - IDLE: ONE(k) → CAND, latch cand=k, cnt=1. NONE or MULTI → stay in IDLE.
  - CAND:
    - ONE(cand) → cnt+1.
    - When cnt reaches DEBOUNCE → PRESSED and accept.
    - Any other result → IDLE.
    - If DEBOUNCE=1, the first ONE(k) in IDLE accepts immediately.
  - PRESSED:
    - NONE → RELEASE, cnt=1.
    - ONE or MULTI → stay in PRESSED. No second report, even for a different key.
  - RELEASE:
    - NONE → cnt+1; when cnt reaches DEBOUNCE → IDLE.
    - ONE or MULTI → PRESSED.
- Accept, on the cycle after the sweep end:
  - key_valid=1 for exactly one cycle.
  - key_code=cand.
  - x = {x[11:0], cand}; the oldest digit is discarded.
- ent_clr:
  - Sets x=0 next cycle; does not affect the FSM or the scan.
  - If ent_clr coincides with an accept, the result is x={12'h000, cand} and key_valid still pulses.
- Reset mid-press: returns to IDLE. A key still held after reset is reported once after DEBOUNCE sweeps.
- Counter widths: sized by $clog2 of the parameters; no overflow (cnt saturates at DEBOUNCE).

Test Plan (SCAN_DIV=4, DEBOUNCE=2, sweep=16 cycles):
- Reset, no keys:
  - col cycles 1110→1101→1011→0111, changing every 4 clk.
  - key_valid stays 0; x=0000.
- Hold key '5' (row1, col1) for 4 sweeps, then release:
  - Exactly one key_valid pulse, one cycle after the 2nd full sweep end.
  - key_code=5; x=0005.
- Press/release '1','2','A','0' in sequence, each held 3 sweeps with 3 sweeps released: x=12A0. Then press 'F': x=2A0F.
- Bounce:
  - Key '7' present 1 sweep, absent 1, present 1, then absent → no pulse; x unchanged.
  - Key '7' held for 2 clean sweeps → one pulse, key_code=7.
- Hold '3' then add '9' while held (MULTI), then release both for 2 sweeps: single pulse for '3' only; FSM returns to IDLE.
- Reset during key hold:
  - clr=0 mid-sweep → outputs return to reset values immediately.
  - After clr=1, with the key still held → one pulse after 2 sweeps.
  - ent_clr during an accept → x={12'h000, code}.
